// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for one shared DATA_W-bit bus with four requesters.
// It drives the tri-state buffer enables and the registered one-hot grant.
// At most one enable is high in any cycle. Every change of owner passes
// through one dead cycle with all enables low.
//
// Ports
//   clk      in   1              system clock, rising edge
//   rst      in   1              asynchronous active-high reset
//   req      in   N_REQ          level-sensitive request lines
//   data_in  in   N_REQ*DATA_W   requester data, slice i = [i*DATA_W +: DATA_W]
//   gnt      out  N_REQ          registered one-hot grant
//   bus_oe   out  N_REQ          buffer enables, identical to gnt
//   bus_out  out  DATA_W         owner's data slice while granted, else 0
//   gnt_id   out  2              index of the current or most recent owner
//   busy     out  1              high in GRANT and TURN
//   timeout  out  1              one-cycle pulse on a forced release
//
// Optional feature
//   ARB_TIMEOUT_EN : builds an 8-bit hold counter. An owner that keeps its
//                    request high is released after MAX_HOLD GRANT cycles.
//                    Without this macro, grants are unbounded and timeout is 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; arbitrate every cycle
// GRANT | owner drives the bus until it drops req (or hold expires)
// TURN  | one dead cycle, all enables low; arbitrate using new ptr
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 16,
   parameter int MAX_HOLD = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   data_in,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          bus_oe,
   output logic [DATA_W-1:0]         bus_out,
   output logic [1:0]                gnt_id,
   output logic                      busy,
   output logic                      timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   // The 2-bit pointer and gnt_id only work for exactly four requesters.
   if (N_REQ != 4) begin : g_bad_nreq
      $error("bus_arbiter: N_REQ must be 4");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("bus_arbiter: MAX_HOLD must be in 1..255");
   end

   state_t       state, state_n;
   logic [3:0]   gnt_q, gnt_n;
   logic [1:0]   owner, owner_n;
   logic [1:0]   ptr, ptr_n;
   logic [1:0]   win;
   logic         any_req;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0]   hold, hold_n;
   logic         timeout_q, timeout_n;
`endif

   // First set request bit in the order ptr, ptr+1, ... (mod 4). Scanning
   // from the far end down lets the nearest candidate overwrite the result.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   assign any_req = |req;
   assign win     = pick(req, ptr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt_q <= '0;
         owner <= '0;
         ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
         hold      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state <= state_n;
         gnt_q <= gnt_n;
         owner <= owner_n;
         ptr   <= ptr_n;
`ifdef ARB_TIMEOUT_EN
         hold      <= hold_n;
         timeout_q <= timeout_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt_q;
      owner_n = owner;
      ptr_n   = ptr;
`ifdef ARB_TIMEOUT_EN
      hold_n    = hold;
      timeout_n = 1'b0;
`endif
      case (state)
         IDLE, TURN: begin
            if (any_req) begin
               state_n = GRANT;
               owner_n = win;
               gnt_n   = 4'b0001 << win;
`ifdef ARB_TIMEOUT_EN
               hold_n  = '0;
`endif
            end else begin
               state_n = IDLE;
               gnt_n   = '0;
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               state_n = TURN;
               gnt_n   = '0;
               ptr_n   = owner + 2'd1;
            end
`ifdef ARB_TIMEOUT_EN
            // hold counts completed GRANT cycles minus one, so reaching
            // HOLD_LAST means this edge ends the MAX_HOLD-th cycle.
            else if (hold == HOLD_LAST) begin
               state_n   = TURN;
               gnt_n     = '0;
               ptr_n     = owner + 2'd1;
               timeout_n = 1'b1;
            end else begin
               hold_n = hold + 8'd1;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      bus_out = '0;
      if (state == GRANT) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (owner == 2'(i)) bus_out = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   assign gnt    = gnt_q;
   assign bus_oe = gnt_q;
   assign gnt_id = owner;
   assign busy   = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

   localparam int N_REQ    = 4;
   localparam int DATA_W   = 16;
   localparam int MAX_HOLD = 15;

   logic                    clk;
   logic                    rst;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] data_in;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        bus_oe;
   logic [DATA_W-1:0]       bus_out;
   logic [1:0]              gnt_id;
   logic                    busy;
   logic                    timeout;

   int n_checks = 0;
   int n_fail   = 0;

   bus_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data_in (data_in),
      .gnt     (gnt),
      .bus_oe  (bus_oe),
      .bus_out (bus_out),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index (-1 = nobody), rotating pointer, dead-cycle
   // flag, last owner, GRANT cycles served so far, and timeout pulse.
   int m_owner = -1;
   int m_ptr   = 0;
   bit m_turn  = 0;
   int m_id    = 0;
   int m_held  = 0;
   bit m_to    = 0;

   function automatic logic [3:0] exp_gnt();
      return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
   endfunction

   function automatic logic [15:0] exp_bus();
      return (m_owner >= 0) ? data_in[m_owner*DATA_W +: DATA_W] : 16'h0000;
   endfunction

   function automatic bit exp_busy();
      return (m_owner >= 0) || m_turn;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_turn = 0; m_id = 0; m_held = 0; m_to = 0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      bit release_now;
      m_to = 0;
      if (m_owner >= 0) begin
         release_now = !r[m_owner];
`ifdef ARB_TIMEOUT_EN
         if (!release_now && m_held == MAX_HOLD) begin
            release_now = 1;
            m_to = 1;
         end
`endif
         if (release_now) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_turn  = 1;
         end else begin
            m_held++;
         end
      end else begin
         m_turn = 0;
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
               m_owner = (m_ptr + k) % 4;
               m_id    = m_owner;
               m_held  = 1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_edge(req);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      n_checks++; if (bus_oe !== 4'b0) begin n_fail++; $display("FAIL reset_bus_oe got=%b want=0000", bus_oe); end
      n_checks++; if (bus_out !== 16'h0) begin n_fail++; $display("FAIL reset_bus_out got=%h want=0000", bus_out); end
      n_checks++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b want=0", timeout); end
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0010;
      step();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL pre_reset_grant got=%b want=0010", gnt); end
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL async_reset_gnt got=%b want=0000", gnt); end
      n_checks++; if (bus_oe !== 4'b0) begin n_fail++; $display("FAIL async_reset_bus_oe got=%b want=0000", bus_oe); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got=%b want=0", busy); end
      @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL post_reset_grant got=%b want=0010", gnt); end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_single_grant();
      do_reset();
      data_in = {$urandom, $urandom, $urandom, $urandom};
      data_in[2*DATA_W +: DATA_W] = 16'hA5C3;
      req = 4'b0100;
      step();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b want=0100", gnt); end
      n_checks++; if (gnt_id !== 2'd2) begin n_fail++; $display("FAIL single_gnt_id got=%0d want=2", gnt_id); end
      n_checks++; if (bus_out !== 16'hA5C3) begin n_fail++; $display("FAIL single_bus_out got=%h want=a5c3", bus_out); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b want=1", busy); end
      req = 4'b0000;
      step();
      n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL single_release_gnt got=%b want=0000", gnt); end
      n_checks++; if (bus_out !== 16'h0) begin n_fail++; $display("FAIL single_release_bus got=%h want=0000", bus_out); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_turn_busy got=%b want=1", busy); end
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got=%b want=0", busy); end
      n_checks++; if (gnt_id !== 2'd2) begin n_fail++; $display("FAIL single_gnt_id_hold got=%0d want=2", gnt_id); end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] want;
      do_reset();
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         step();
         want = 4'(1 << order[n]);
         n_checks++; if (gnt !== want) begin n_fail++; $display("FAIL rr_grant%0d got=%b want=%b", n, gnt, want); end
         n_checks++; if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rr_model%0d got=%b want=%b", n, gnt, exp_gnt()); end
         step();
         n_checks++; if (gnt !== want) begin n_fail++; $display("FAIL rr_hold%0d got=%b want=%b", n, gnt, want); end
         req = 4'b1111 & ~want;
         step();
         n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL rr_dead%0d got=%b want=0000", n, gnt); end
         req = 4'b1111;
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_priority_rotation();
      do_reset();
      req = 4'b0010;
      step();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rot_owner1 got=%b want=0010", gnt); end
      req = 4'b0011;
      step();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rot_no_preempt got=%b want=0010", gnt); end
      req = 4'b0001;
      step();
      n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL rot_turn got=%b want=0000", gnt); end
      req = 4'b0011;
      step();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rot_winner got=%b want=0001", gnt); end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b1001;
      step();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL to_first got=%b want=0001", gnt); end
      for (int c = 2; c <= MAX_HOLD; c++) step();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL to_held got=%b want=0001", gnt); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_early got=%b want=0", timeout); end
      step();
`ifdef ARB_TIMEOUT_EN
      n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%b want=1", timeout); end
      n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL to_turn got=%b want=0000", gnt); end
      step();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL to_next got=%b want=1000", gnt); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end got=%b want=0", timeout); end
`else
      for (int c = 0; c < 30; c++) begin
         n_checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_unbounded%0d got=%b/%b want=0001/0", c, gnt, timeout);
         end
         step();
      end
`endif
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_contention();
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         req = 4'($urandom_range(0, 15));
         data_in = {$urandom, $urandom, $urandom, $urandom};
         step();
         n_checks++; if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt()); end
         n_checks++; if (bus_oe !== gnt) begin n_fail++; $display("FAIL rand_oe_eq c=%0d got=%b want=%b", c, bus_oe, gnt); end
         n_checks++; if ($countones(bus_oe) > 1) begin n_fail++; $display("FAIL rand_onehot c=%0d got=%b want=popcount<=1", c, bus_oe); end
         n_checks++; if (bus_out !== exp_bus()) begin n_fail++; $display("FAIL rand_bus c=%0d got=%h want=%h", c, bus_out, exp_bus()); end
         n_checks++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, exp_busy()); end
         n_checks++; if (gnt_id !== 2'(m_id)) begin n_fail++; $display("FAIL rand_id c=%0d got=%0d want=%0d", c, gnt_id, m_id); end
         n_checks++; if (timeout !== m_to) begin n_fail++; $display("FAIL rand_to c=%0d got=%b want=%b", c, timeout, m_to); end
      end
      req = 4'b0000;
      step();
      step();
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      data_in = '0;
      #2;
      test_reset();
      test_single_grant();
      test_round_robin();
      test_priority_rotation();
      test_timeout();
      test_contention();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one 16-bit datapath bus among four requesters. It owns the tri-state enables (bufif1-style, active-high) that drive the shared bus, and the registered grant handshake. It guarantees at most one driver per cycle and a dead cycle between owners. It sits between the requesting units and the shared-bus buffer bank, next to the gate-level datapath.

## Interface
Parameters:
- N_REQ, 4: number of requesters. Fixed at 4; `gnt_id` is 2 bits wide.
- DATA_W, 16: bus width.
- MAX_HOLD, 15: maximum consecutive GRANT cycles per owner. Used only with `ARB_TIMEOUT_EN`. Legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request lines; bit i belongs to requester i; level-sensitive.
- data_in  in  N_REQ*DATA_W  requester data; slice i is [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  registered one-hot grant; all zero when no owner.
- bus_oe  out  N_REQ  tri-state buffer enables; equal to `gnt` bit for bit.
- bus_out  out  DATA_W  muxed data: owner's slice in GRANT, otherwise 0.
- gnt_id  out  2  index of the current or most recent owner.
- busy  out  1  high in GRANT and TURN.
- timeout  out  1  one-cycle pulse on a forced release; constant 0 without the macro.

## Operation
- Reset state: `gnt`=0, `bus_oe`=0, `bus_out`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, state IDLE.
- `ptr` (2 bits) holds the highest-priority index. Priority order is ptr, ptr+1, ... mod 4.
- State IDLE:
  - If `req`≠0, register a grant to the first set bit in priority order and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - While `req[owner]`=1, stay in GRANT.
  - When `req[owner]`=0, go to TURN. `gnt` and `bus_oe` clear, and `ptr` ← owner+1 mod 4.
  - Requests from other requesters are ignored in GRANT. There is no preemption.
- State TURN: exactly one cycle with all enables low.
  - During that cycle, arbitrate exactly as in IDLE.
  - If a winner exists, go to GRANT with the new one-hot grant. Otherwise go to IDLE.
- `bus_out` is a combinational mux of `data_in` selected by the registered owner. It is 0 outside GRANT.
- `gnt_id` updates when a grant is issued and holds through TURN and IDLE.
- Invariant: popcount(`bus_oe`) ≤ 1 every cycle, including the reset edge.
- Reset mid-grant: all outputs clear immediately (asynchronously) and `ptr` returns to 0. Pending requests are re-arbitrated from index 0 after `rst` drops.

## Timing
- Grant latency: `req[i]` sampled high at edge k in IDLE or TURN → `gnt[i]`=1 after edge k.
- Release: `req[owner]` sampled low at edge k → `gnt`=0 after edge k (TURN). The earliest next grant appears after edge k+1, giving exactly one dead bus cycle.
- A single requester holding `req` continuously keeps its grant with no gaps.
- Back-to-back requests from the same requester: it re-wins only if no other request is pending. After its release it holds the lowest priority.
- Simultaneous release by the owner and new requests: the TURN cycle arbitrates using the updated `ptr`.
- Requests that drop before being sampled are lost. No latching is done.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the owner has been granted for MAX_HOLD cycles and `req[owner]` is still 1, the arbiter forces TURN.
  - `timeout` pulses high for that TURN cycle, and `ptr` ← owner+1 mod 4.
  - The owner may re-win later under normal round-robin.
- `ARB_TIMEOUT_EN` undefined: no counter is built, grants are unbounded, and `timeout` is tied to 0.

## Test plan
- Reset and idle: assert `rst` mid-grant with `req`=4'b0010 → `gnt`, `bus_oe`, `busy` drop to 0 immediately without waiting for an edge. After release, `gnt`=4'b0010 one cycle later.
- Single grant and data: `req`=4'b0100, `data_in` slice 2 = 16'hA5C3 → after 1 edge `gnt`=4'b0100, `gnt_id`=2, `bus_out`=16'hA5C3. Drop `req` → `gnt`=0 and `bus_out`=0 next cycle.
- Round-robin fairness: hold `req`=4'b1111 with each owner releasing after 2 GRANT cycles → grant order 0,1,2,3,0. Exactly one cycle with `gnt`=0 between owners.
- Contention safety: random `req` for 10,000 cycles → popcount(`bus_oe`) ≤ 1 every cycle, and `bus_oe`==`gnt` at all times.
- Priority rotation: requester 1 owns the bus, then releases while `req`=4'b0011 → requester 0 is granted, not requester 1.
- Timeout, with the macro and MAX_HOLD=15: `req`=4'b1001 held, requester 0 wins → forced TURN after 15 GRANT cycles, `timeout`=1 for that cycle, requester 3 granted next. Without the macro, requester 0 holds the bus indefinitely and `timeout` stays 0.
